// File: rtl/fclk_pkg.sv
// fclk_pkg: shared types and defaults for the slow CPU clock generator.
// Optional step-button debounce is enabled by defining FCLK_STEP_DEBOUNCE_EN.
package fclk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } fclk_state_e;

  localparam int unsigned DIV_W_DEF           = 16;
  localparam int unsigned CNT_W_DEF           = 32;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1_000_000;

  // Smallest legal half-period; a divisor of 0 is promoted to this.
  localparam int unsigned MIN_HALF = 1;

endpackage

// File: rtl/fclk_step_input.sv
// fclk_step_input: turns the raw step push-button into a one-CLK step pulse.
// Two-flop synchronizer, optional debounce (FCLK_STEP_DEBOUNCE_EN), then a
// registered rising-edge detector. Without debounce the pulse appears 3 CLK
// after the button edge.
module fclk_step_input
  import fclk_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic CLK,
  input  logic rst,
  input  logic step_btn_i,
  output logic step_pulse_o
);

  logic sync1_q;
  logic sync2_q;
  logic level_prev_q;
  logic pulse_q;
  logic level;

  // Bring the asynchronous button into the CLK domain.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= step_btn_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef FCLK_STEP_DEBOUNCE_EN
  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [DB_W-1:0] db_cnt_q;
  logic            db_level_q;

  // Accept a new level only after it has been stable for DEBOUNCE_CYCLES CLKs.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      db_cnt_q   <= '0;
      db_level_q <= 1'b0;
    end else if (sync2_q == db_level_q) begin
      db_cnt_q <= '0;
    end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      db_cnt_q   <= '0;
      db_level_q <= sync2_q;
    end else begin
      db_cnt_q <= db_cnt_q + 1'b1;
    end
  end

  assign level = db_level_q;
`else
  assign level = sync2_q;
`endif

  // Registered rising-edge detect so the pulse is exactly one CLK wide.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      level_prev_q <= 1'b0;
      pulse_q      <= 1'b0;
    end else begin
      level_prev_q <= level;
      pulse_q      <= level & ~level_prev_q;
    end
  end

  assign step_pulse_o = pulse_q;

endmodule

// File: rtl/fclk_gen.sv
// fclk_gen: slow CPU clock generator with free-run, single-step and halt.
// fclk is a registered level in the CLK domain; the divisor is only picked up
// at a rising edge so periods are never cut short by a rate change.
// Optional step-button debounce is enabled by defining FCLK_STEP_DEBOUNCE_EN.
module fclk_gen
  import fclk_pkg::*;
#(
  parameter int unsigned DIV_W           = DIV_W_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             run,
  input  logic             step_btn,
  input  logic             halt,
  input  logic [DIV_W-1:0] div_half,
  output logic             fclk,
  output logic [CNT_W-1:0] fclk_count,
  output logic             active,
  output logic             step_done
);

  fclk_state_e      state_q, state_d;
  logic             fclk_q, fclk_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] half_q, half_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] count_q;
  logic             step_pulse;
  logic [DIV_W-1:0] div_eff;
  logic             phase_end;

  fclk_step_input #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_input (
    .CLK         (CLK),
    .rst         (rst),
    .step_btn_i  (step_btn),
    .step_pulse_o(step_pulse)
  );

  assign div_eff   = (div_half == '0) ? DIV_W'(MIN_HALF) : div_half;
  assign phase_end = (cnt_q == half_q - 1'b1);

  // Next-state logic: halt overrides everything; otherwise launch, count phases,
  // and decide at the end of each low phase whether to start another period.
  always_comb begin
    state_d = state_q;
    fclk_d  = fclk_q;
    cnt_d   = cnt_q;
    half_d  = half_q;
    done_d  = 1'b0;
    if (halt) begin
      state_d = IDLE;
      fclk_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          fclk_d = 1'b0;
          cnt_d  = '0;
          half_d = div_eff;
          if (run) begin
            state_d = RUN;
            fclk_d  = 1'b1;
          end else if (step_pulse) begin
            state_d = FINISH;
            fclk_d  = 1'b1;
          end
        end
        RUN, FINISH: begin
          // run decides whether the period in flight is the last one.
          state_d = run ? RUN : FINISH;
          if (!phase_end) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            cnt_d = '0;
            if (fclk_q) begin
              fclk_d = 1'b0;
            end else if (run) begin
              fclk_d = 1'b1;
              half_d = div_eff;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          fclk_d  = 1'b0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, phase counter and output registers; count every fclk rising edge.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      fclk_q  <= 1'b0;
      cnt_q   <= '0;
      half_q  <= DIV_W'(MIN_HALF);
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      fclk_q  <= fclk_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      done_q  <= done_d;
      if (fclk_d && !fclk_q) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  assign fclk       = fclk_q;
  assign fclk_count = count_q;
  assign active     = (state_q != IDLE);
  assign step_done  = done_q;

endmodule

// File: tb/tb_fclk_gen.sv
// tb_fclk_gen: directed scenarios plus randomized traffic for fclk_gen,
// compared cycle by cycle against a phase-countdown reference model.
`timescale 1ns/1ps
module tb_fclk_gen;
  localparam int DIV_W = 16;
  localparam int CNT_W = 32;
  localparam int DEB   = 8;

  logic             CLK      = 1'b0;
  logic             rst      = 1'b1;
  logic             run      = 1'b0;
  logic             step_btn = 1'b0;
  logic             halt     = 1'b0;
  logic [DIV_W-1:0] div_half = 16'd2;
  logic             fclk;
  logic [CNT_W-1:0] fclk_count;
  logic             active;
  logic             step_done;

  int checks   = 0;
  int failures = 0;

  // Reference model: generator on/off, current level, CLKs left in the phase.
  bit          m_on, m_hi, m_done;
  int          m_left, m_half;
  longint      m_rises;
  bit          bs [5];
  bit          model_en = 1'b1;

  // Observation counters kept by the bench.
  bit prev_fclk, rose_now;
  int rises, done_seen, hi_cycles;
  int n, w;

  fclk_gen #(
    .DIV_W          (DIV_W),
    .CNT_W          (CNT_W),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .CLK       (CLK),
    .rst       (rst),
    .run       (run),
    .step_btn  (step_btn),
    .halt      (halt),
    .div_half  (div_half),
    .fclk      (fclk),
    .fclk_count(fclk_count),
    .active    (active),
    .step_done (step_done)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one CLK edge using the inputs presented to that edge.
  task automatic model_step();
    int eff;
    bit pulse;
    if (rst) begin
      m_on = 0; m_hi = 0; m_done = 0; m_rises = 0; m_half = 1; m_left = 0;
      for (int i = 0; i < 5; i++) bs[i] = 0;
      return;
    end
    for (int i = 4; i > 0; i--) bs[i] = bs[i-1];
    bs[0] = step_btn;
`ifdef FCLK_STEP_DEBOUNCE_EN
    pulse = 0;
`else
    // A button edge reaches the generator on the fourth edge after it.
    pulse = bs[3] & ~bs[4];
`endif
    eff    = (div_half == 0) ? 1 : int'(div_half);
    m_done = 0;
    if (halt) begin
      m_on = 0;
      m_hi = 0;
    end else if (!m_on) begin
      m_half = eff;
      if (run || pulse) begin
        m_on = 1; m_hi = 1; m_left = m_half; m_rises++;
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        if (m_hi) begin
          m_hi = 0; m_left = m_half;
        end else if (run) begin
          m_half = eff; m_hi = 1; m_left = m_half; m_rises++;
        end else begin
          m_on = 0; m_done = 1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
    if (model_en) begin
      chk("fclk", {63'd0, fclk}, {63'd0, m_hi});
      chk("active", {63'd0, active}, {63'd0, m_on});
      chk("step_done", {63'd0, step_done}, {63'd0, m_done});
      chk("fclk_count", {32'd0, fclk_count}, m_rises & 64'hFFFF_FFFF);
    end
    rose_now = (fclk === 1'b1) && !prev_fclk;
    prev_fclk = (fclk === 1'b1);
    if (rose_now) rises++;
    if (step_done === 1'b1) done_seen++;
    if (fclk === 1'b1) hi_cycles++;
  endtask

  task automatic wait_rise(input string tag);
    int k;
    k = 0;
    rose_now = 0;
    while (!rose_now && k < 40) begin
      tick();
      k++;
    end
    if (!rose_now) chk({tag, "_rise_timeout"}, 64'(k), 64'd0);
  endtask

  task automatic drain();
    run = 0; halt = 0; step_btn = 0;
    repeat (20) tick();
  endtask

  initial begin
    // Reset
    repeat (2) tick();
    chk("rst_fclk", {63'd0, fclk}, 64'd0);
    chk("rst_count", {32'd0, fclk_count}, 64'd0);
    chk("rst_active", {63'd0, active}, 64'd0);
    chk("rst_done", {63'd0, step_done}, 64'd0);
    rst = 0;
    $display("scenario reset checks=%0d", checks);

    // Free run, div_half=2
    div_half = 2;
    repeat (2) tick();
    run = 1;
    tick();
    chk("freerun_first_rise", {63'd0, fclk}, 64'd1);
    repeat (11) tick();
    chk("freerun_count12", {32'd0, fclk_count}, 64'd3);
    $display("scenario free_run checks=%0d", checks);

    // Rate change mid-high-phase: 2 -> 5
    wait_rise("rate");
    div_half = 5;
    n = 0;
    do begin tick(); n++; end while (!rose_now && n < 20);
    chk("rate_cur_period", 64'(n), 64'd4);
    w = 1;
    while (fclk === 1'b1 && w < 20) begin tick(); if (fclk === 1'b1) w++; end
    chk("rate_next_high", 64'(w), 64'd5);
    $display("scenario rate_change checks=%0d", checks);

    // Stop: drop run one CLK after a rise with div_half=4
    div_half = 4;
    wait_rise("stop_pre");
    wait_rise("stop");
    tick();
    run = 0;
    done_seen = 0;
    n = 1;
    while (active === 1'b1 && n < 30) begin tick(); n++; end
    chk("stop_len", 64'(n), 64'd8);
    repeat (4) tick();
    chk("stop_done_once", 64'(done_seen), 64'd1);
    $display("scenario stop checks=%0d", checks);

    // Halt during high phase
    div_half = 3;
    run = 1;
    wait_rise("halt");
    tick();
    halt = 1;
    done_seen = 0;
    tick();
    chk("halt_fclk", {63'd0, fclk}, 64'd0);
    chk("halt_active", {63'd0, active}, 64'd0);
    halt = 0; run = 0;
    repeat (8) tick();
    chk("halt_no_done", 64'(done_seen), 64'd0);
    $display("scenario halt checks=%0d", checks);

    // div_half=0 behaves as 1
    div_half = 0;
    run = 1;
    wait_rise("div0");
    n = 0;
    do begin tick(); n++; end while (!rose_now && n < 20);
    chk("div0_period", 64'(n), 64'd2);
    drain();
    $display("scenario div_zero checks=%0d", checks);

`ifndef FCLK_STEP_DEBOUNCE_EN
    // Single step: button held 10 CLK, div_half=3
    div_half = 3;
    rises = 0; done_seen = 0; hi_cycles = 0;
    step_btn = 1;
    repeat (10) tick();
    step_btn = 0;
    repeat (15) tick();
    chk("step_rises", 64'(rises), 64'd1);
    chk("step_high_len", 64'(hi_cycles), 64'd3);
    chk("step_done_once", 64'(done_seen), 64'd1);
    chk("step_active_end", {63'd0, active}, 64'd0);
    $display("scenario single_step checks=%0d", checks);

    // run and step pulse on the same edge: run wins
    div_half = 2;
    step_btn = 1;
    repeat (3) tick();
    run = 1;
    rises = 0; done_seen = 0;
    repeat (8) tick();
    chk("runstep_rises", 64'(rises), 64'd2);
    chk("runstep_active", {63'd0, active}, 64'd1);
    drain();
    $display("scenario run_and_step checks=%0d", checks);
`endif

    // Asynchronous reset mid-run
    div_half = 3;
    run = 1;
    repeat (5) tick();
    #2 rst = 1;
    #1;
    chk("arst_fclk", {63'd0, fclk}, 64'd0);
    chk("arst_count", {32'd0, fclk_count}, 64'd0);
    chk("arst_active", {63'd0, active}, 64'd0);
    run = 0;
    tick();
    rst = 0;
    repeat (2) tick();
    $display("scenario async_reset checks=%0d", checks);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) run = ~run;
      halt = ($urandom_range(0, 59) == 0);
`ifndef FCLK_STEP_DEBOUNCE_EN
      if ($urandom_range(0, 7) == 0) step_btn = ~step_btn;
`endif
      if ($urandom_range(0, 29) == 0) div_half = DIV_W'($urandom_range(0, 6));
      tick();
    end
    drain();
    $display("scenario random checks=%0d", checks);

`ifdef FCLK_STEP_DEBOUNCE_EN
    // Debounce: a short bounce is ignored, a long press gives one step
    model_en = 0;
    div_half = 2;
    rises = 0; done_seen = 0;
    step_btn = 1;
    repeat (5) tick();
    step_btn = 0;
    repeat (30) tick();
    chk("debounce_bounce_rises", 64'(rises), 64'd0);
    step_btn = 1;
    repeat (20) tick();
    step_btn = 0;
    repeat (30) tick();
    chk("debounce_press_rises", 64'(rises), 64'd1);
    chk("debounce_press_done", 64'(done_seen), 64'd1);
    $display("scenario debounce checks=%0d", checks);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fclk_gen.md
Name: fclk_gen

Overview:
- Generates the slow CPU clock `fclk` from the system clock `CLK`; it sits directly upstream of the fclk rising-edge detector.
- The CPU pipeline advances only on detected `fclk` rising edges, so this block decides when and how often the CPU steps.
- Modes: free-running at a programmable rate, single-step from a push-button, and immediate halt.
- `fclk` is a registered, glitch-free level in the `CLK` domain.

Parameters:
- DIV_W, 16: width of the half-period divisor input.
- CNT_W, 32: width of the fclk rising-edge counter.
- DEBOUNCE_CYCLES, 1_000_000: CLK cycles the step button must be stable; used only with the optional feature.

Ports:
- CLK  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- run  input  1  level; 1 = free-run fclk.
- step_btn  input  1  raw asynchronous push-button; each press gives one fclk period.
- halt  input  1  synchronous abort; forces fclk low and returns to IDLE.
- div_half  input  DIV_W  fclk half-period in CLK cycles; 0 is treated as 1.
- fclk  output  1  generated slow clock (registered).
- fclk_count  output  CNT_W  number of fclk rising edges since reset.
- active  output  1  1 when state is not IDLE.
- step_done  output  1  one-CLK pulse when a period in FINISH completes.

Behaviour:
- Reset (rst is asynchronous, active-high; clock is CLK): state = IDLE; fclk, fclk_count, step_done, cnt, sync/edge regs all 0; half_q = max(div_half, 1) sampled at the first post-reset edge.
- step_btn handling:
  - Passed through a 2-FF synchronizer.
  - A rising edge of the synchronized signal gives a one-CLK step_pulse.
  - Latency from button edge to step_pulse: 3 CLK.
- States: IDLE, RUN, FINISH.
- IDLE: fclk = 0, cnt = 0.
  - run=1 → RUN. On the same edge: fclk<=1, cnt<=0, half_q<=max(div_half,1).
  - Else step_pulse → FINISH, with the same launch actions.
  - run and step_pulse together: run wins; the step is dropped.
- High phase (fclk=1), in RUN or FINISH: cnt increments each CLK. At cnt==half_q-1: fclk<=0, cnt<=0.
- Low phase in RUN: at cnt==half_q-1: fclk<=1, cnt<=0, half_q<=max(div_half,1).
  - div_half changes therefore take effect only at a rising edge.
  - Never mid-period.
- RUN with run=0 (either phase) → FINISH. The counter and fclk are unaffected, so the current period completes in full.
- Low phase in FINISH: at cnt==half_q-1: state<=IDLE, step_done<=1 for one CLK, fclk stays 0.
  - run=1 observed in FINISH → back to RUN, with no idle gap.
- step_pulse in RUN or FINISH is ignored (not queued).
- halt=1 has priority over everything in any state: fclk<=0, cnt<=0, state<=IDLE, no step_done.
  - A truncated high phase is allowed; downstream logic only uses rising edges.
- fclk_count increments on every 0→1 transition of fclk. It wraps modulo 2^CNT_W.
- Period in RUN: 2*half_q CLK cycles, 50% duty.
- Latency from run rise (registered input) to fclk rise: 1 CLK.
- active = (state != IDLE), registered with the state.
- rst asserted mid-operation: all outputs go to their reset values immediately, since reset is asynchronous.

Optional Feature:
- Macro: FCLK_STEP_DEBOUNCE_EN.
- Defined:
  - The synchronized button must hold its new level for DEBOUNCE_CYCLES consecutive CLK cycles before the debounced level updates.
  - step_pulse comes from the debounced level's rising edge.
  - Bounces shorter than DEBOUNCE_CYCLES produce no pulse.
- Undefined: step_pulse comes directly from the synchronized level (3-CLK latency), and the debounce counter is absent.

Decomposition:
- Shared package fclk_pkg holds:
  - the state enum (IDLE, RUN, FINISH);
  - defaults for DIV_W, CNT_W and DEBOUNCE_CYCLES;
  - the constant MIN_HALF = 1.
- One sub-module is natural: fclk_step_input.
  - It contains the synchronizer, the optional debounce and the edge pulse.
  - Output: step_pulse.

Test Plan:
- Free run: div_half=2; run raised at cycle T (registered) → fclk=1 during T+1..T+2 and 0 during T+3..T+4, repeating with period 4; fclk_count=3 after 12 CLK.
- Single step: div_half=3, run=0; step_btn pulse held 10 CLK → exactly one fclk high for 3 CLK and low for 3; step_done pulses once; active returns to 0; fclk_count=1.
- Rate change: run with div_half=2, then switch to 5 mid-high-phase → the current period stays at 4 CLK; the next high phase lasts 5 CLK.
- Stop: deassert run one CLK after an fclk rise with div_half=4 → fclk completes 4 high + 4 low, then IDLE; step_done=1 once.
- Halt/abort: halt during high phase → fclk=0 next CLK, state IDLE, no step_done. Also, rst asserted mid-RUN → fclk=0 and fclk_count=0 immediately.
- Edge cases:
  - div_half=0 → behaves as 1 (period 2 CLK).
  - run and step together in IDLE → RUN, and exactly one rising edge per 2*half_q.
  - With FCLK_STEP_DEBOUNCE_EN and DEBOUNCE_CYCLES=8, a 5-CLK bounce → no step.
